// File: rtl/guid_filter_seq.sv
// Frame sequencer for the guided-filter datapath: pixel coordinates, frame-latched settings, aligned output timing.
// Define GUID_SEQ_STAT_EN to add the o_frm_cnt / o_err_cnt statistics outputs.
module guid_filter_seq #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 512,
  parameter int CNT_W    = 11,
  parameter int DAT_W    = 14,
  parameter int PIPE_DLY = 652,
  parameter int EPS_W    = 28,
  parameter int EPS_DEF  = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic             i_fs,
  input  logic [DAT_W-1:0] i_dat,
  input  logic             i_en_req,
  input  logic [EPS_W-1:0] i_eps,
  input  logic             i_eps_wr,
  output logic             o_pix_vld,
  output logic [DAT_W-1:0] o_pix_dat,
  output logic [CNT_W-1:0] o_cnt_x,
  output logic [CNT_W-1:0] o_cnt_y,
  output logic             o_ctrl,
  output logic [EPS_W-1:0] o_eps,
  output logic             o_out_vld,
  output logic [CNT_W-1:0] o_out_x,
  output logic [CNT_W-1:0] o_out_y,
  output logic             o_ctrl_out,
  output logic             o_fe,
  output logic             o_busy,
  output logic             o_err
`ifdef GUID_SEQ_STAT_EN
  ,
  output logic [15:0]      o_frm_cnt,
  output logic [15:0]      o_err_cnt
`endif
);

  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(IMG_H - 1);
  localparam logic [EPS_W-1:0] EPS_RST = EPS_W'(EPS_DEF);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  // One delay-line slot: pixel valid, frame ctrl, and frame-first marker.
  typedef struct packed {
    logic vld;
    logic ctrl;
    logic first;
  } dl_t;

  // Raster step shared by the input and output coordinate counters.
  function automatic logic [2*CNT_W-1:0] step_xy(input logic [CNT_W-1:0] x,
                                                 input logic [CNT_W-1:0] y);
    logic [CNT_W-1:0] nx;
    logic [CNT_W-1:0] ny;
    nx = x + CNT_W'(1);
    ny = y;
    if (x == X_LAST) begin
      nx = '0;
      ny = (y == Y_LAST) ? '0 : y + CNT_W'(1);
    end
    return {ny, nx};
  endfunction

  state_e           state_q, state_d;
  logic             accept, first, err;
  logic [CNT_W-1:0] acc_x, acc_y;
  logic             acc_last;

  logic             pix_vld_q;
  logic [DAT_W-1:0] pix_dat_q;
  logic [CNT_W-1:0] cnt_x_q, cnt_y_q;
  logic             ctrl_q, ctrl_d;
  logic [EPS_W-1:0] eps_q, eps_d;
  logic [EPS_W-1:0] pend_q, pend_d;
  logic             err_q;
  logic             busy_q, busy_d;

  dl_t              dl_q [PIPE_DLY];
  dl_t              tap;
  logic             out_vld_q;
  logic             ctrl_out_q;
  logic [CNT_W-1:0] out_x_q, out_y_q, out_x_d, out_y_d;
  logic             fe_q, fe_d;

  // ---------------------------------------------------------------------------
  // Input FSM: state register / next-state / acceptance decode
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = acc_last ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (acc_last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (accept)    state_d = acc_last ? ST_DRAIN : ST_RUN;
        else if (fe_d) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    accept = 1'b0;
    first  = 1'b0;
    err    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DRAIN: begin
        if (i_vld) begin
          accept = i_fs;
          first  = i_fs;
          err    = !i_fs;
        end
      end
      ST_RUN: begin
        // A frame start inside a running frame restarts it and flags the short frame.
        accept = i_vld;
        first  = i_vld && i_fs;
        err    = i_vld && i_fs;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input side datapath
  // ---------------------------------------------------------------------------
  assign {acc_y, acc_x} = first ? '0 : step_xy(cnt_x_q, cnt_y_q);
  assign acc_last       = accept && (acc_x == X_LAST) && (acc_y == Y_LAST);

  always_comb begin
    ctrl_d = ctrl_q;
    eps_d  = eps_q;
    pend_d = i_eps_wr ? i_eps : pend_q;
    busy_d = busy_q;
    if (first) begin
      ctrl_d = i_en_req;
      eps_d  = pend_d;
      busy_d = 1'b1;
    end else if (fe_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pix_vld_q <= 1'b0;
      pix_dat_q <= '0;
      cnt_x_q   <= '0;
      cnt_y_q   <= '0;
      ctrl_q    <= 1'b0;
      eps_q     <= EPS_RST;
      pend_q    <= EPS_RST;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pix_vld_q <= accept;
      if (accept) begin
        pix_dat_q <= i_dat;
        cnt_x_q   <= acc_x;
        cnt_y_q   <= acc_y;
      end
      ctrl_q    <= ctrl_d;
      eps_q     <= eps_d;
      pend_q    <= pend_d;
      err_q     <= err;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latency delay line: slot i holds the input-side register contents delayed i clocks
  // ---------------------------------------------------------------------------
  // NOTE: this shift register is reset so a mid-frame reset discards everything in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PIPE_DLY; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= '{vld: accept, ctrl: ctrl_d, first: first};
      for (int i = 1; i < PIPE_DLY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // The last slot feeds the output registers, adding the final clock of latency.
  assign tap = dl_q[PIPE_DLY-1];

  always_comb begin
    {out_y_d, out_x_d} = {out_y_q, out_x_q};
    if (tap.vld) {out_y_d, out_x_d} = tap.first ? '0 : step_xy(out_x_q, out_y_q);
    fe_d = tap.vld && (out_x_d == X_LAST) && (out_y_d == Y_LAST);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vld_q  <= 1'b0;
      ctrl_out_q <= 1'b0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      fe_q       <= 1'b0;
    end else begin
      out_vld_q  <= tap.vld;
      ctrl_out_q <= tap.ctrl;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      fe_q       <= fe_d;
    end
  end

`ifdef GUID_SEQ_STAT_EN
  logic [15:0] frm_cnt_q, err_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (fe_d) frm_cnt_q <= frm_cnt_q + 16'd1;
      if (err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_frm_cnt = frm_cnt_q;
  assign o_err_cnt = err_cnt_q;
`endif

  assign o_pix_vld  = pix_vld_q;
  assign o_pix_dat  = pix_dat_q;
  assign o_cnt_x    = cnt_x_q;
  assign o_cnt_y    = cnt_y_q;
  assign o_ctrl     = ctrl_q;
  assign o_eps      = eps_q;
  assign o_out_vld  = out_vld_q;
  assign o_out_x    = out_x_q;
  assign o_out_y    = out_y_q;
  assign o_ctrl_out = ctrl_out_q;
  assign o_fe       = fe_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule
